// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with a data width (5..DATA_BITS_MAX) chosen at run time,
// 1/1.5/2 stop bits, majority-vote input filter and mid-bit sampling.
// Received words leave through a valid/ready handshake, with frame and overrun errors.
// Optional feature macro: UART_RX_PARITY_EN adds the parity_mode port, the PARITY
// state and parity checking. Without it, parity_err is tied to 0.
module uart_rx_cfg #(
    parameter int DATA_BITS_MAX = 9,
    parameter int CTR_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic [CTR_W-1:0]         bit_duration,
    input  logic [3:0]               data_bits,
    input  logic [1:0]               stopbits,
`ifdef UART_RX_PARITY_EN
    input  logic [1:0]               parity_mode,
`endif
    output logic [DATA_BITS_MAX-1:0] data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     overrun_err,
    output logic                     busy
);

    localparam int         CW   = CTR_W + 1;
    localparam logic [3:0] MAXB = 4'(DATA_BITS_MAX);

    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP, LOAD, GUARD
    } state_t;

    // A bit duration below 2 cycles cannot be sampled mid-bit, so it is raised to 2.
    function automatic logic [CW-1:0] clamp_bd(input logic [CTR_W-1:0] v);
        if (v < CTR_W'(2)) return CW'(2);
        return {1'b0, v};
    endfunction

    // Frame width is limited to 5..DATA_BITS_MAX.
    function automatic logic [3:0] clamp_bits(input logic [3:0] v);
        if (v < 4'd5) return 4'd5;
        if (v > MAXB) return MAXB;
        return v;
    endfunction

    state_t                   state_q, state_d;
    logic [1:0]               sync_q, sync_d;
    logic [2:0]               taps_q, taps_d;
    logic                     rxf_q, rxf_d;
    logic                     rxf_prev_q, rxf_prev_d;
    logic [CW-1:0]            ctr_q, ctr_d;
    logic [3:0]               bitcnt_q, bitcnt_d;
    logic [DATA_BITS_MAX-1:0] shreg_q, shreg_d;
    logic [CW-1:0]            bd_q, bd_d;
    logic [3:0]               nbits_q, nbits_d;
    logic [1:0]               stop_q, stop_d;
    logic                     ferr_int_q, ferr_int_d;
    logic [DATA_BITS_MAX-1:0] data_out_q, data_out_d;
    logic                     data_valid_q, data_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic                     overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic [1:0]               par_q, par_d;
    logic                     perr_int_q, perr_int_d;
    logic                     parity_err_q, parity_err_d;
    logic                     par_exp;
`endif

    logic [3:0]               shamt;
    logic [DATA_BITS_MAX-1:0] word;
    logic [CW-1:0]            bd_m1;
    logic [CW-1:0]            extra;
    logic                     rxf_fall;

    // Synchroniser, 3-tap majority filter and falling-edge detector on the filtered line.
    always_comb begin
        sync_d     = {sync_q[0], rx};
        taps_d     = {taps_q[1:0], sync_q[1]};
        rxf_d      = (taps_q[0] & taps_q[1]) | (taps_q[0] & taps_q[2]) | (taps_q[1] & taps_q[2]);
        rxf_prev_d = rxf_q;
    end

    // Shared decodes: right-aligned word, sample point and remaining stop time.
    always_comb begin
        shamt    = MAXB - nbits_q;
        word     = shreg_q >> shamt;
        bd_m1    = bd_q - CW'(1);
        rxf_fall = rxf_prev_q & ~rxf_q;
        case (stop_q)
            2'b00:   extra = '0;
            2'b01:   extra = bd_q >> 1;
            default: extra = bd_q;
        endcase
`ifdef UART_RX_PARITY_EN
        par_exp = (par_q == 2'b10) ? ~(^word) : (^word);
`endif
    end

    // Next-state logic for the frame FSM and the output handshake registers.
    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        bd_d         = bd_q;
        nbits_d      = nbits_q;
        stop_d       = stop_q;
        ferr_int_d   = ferr_int_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        perr_int_d   = perr_int_q;
        parity_err_d = parity_err_q;
`endif
        if (data_valid_q && data_ready) data_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxf_fall) begin
                    bd_d       = clamp_bd(bit_duration);
                    nbits_d    = clamp_bits(data_bits);
                    stop_d     = stopbits;
                    ctr_d      = '0;
                    bitcnt_d   = '0;
                    ferr_int_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_d      = parity_mode;
                    perr_int_d = 1'b0;
`endif
                    state_d    = START;
                end
            end
            START: begin
                if (ctr_q == (bd_q >> 1)) begin
                    ctr_d = '0;
                    if (rxf_q) state_d = IDLE;
                    else       state_d = DATA;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            DATA: begin
                if (ctr_q == bd_m1) begin
                    shreg_d  = {rxf_q, shreg_q[DATA_BITS_MAX-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    ctr_d    = '0;
                    if (bitcnt_q + 4'd1 == nbits_q) begin
`ifdef UART_RX_PARITY_EN
                        if (par_q == 2'b01 || par_q == 2'b10) state_d = PARITY;
                        else                                  state_d = STOP;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (ctr_q == bd_m1) begin
                    perr_int_d = (rxf_q != par_exp);
                    ctr_d      = '0;
                    state_d    = STOP;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (ctr_q == bd_m1) begin
                    ferr_int_d = ~rxf_q;
                    state_d    = LOAD;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            LOAD: begin
                // A word still waiting for the consumer wins; the new one is dropped.
                if (!data_valid_q || data_ready) begin
                    data_out_d   = word;
                    frame_err_d  = ferr_int_q;
                    data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = perr_int_q;
`endif
                end else begin
                    overrun_d = 1'b1;
                end
                ctr_d   = '0;
                state_d = GUARD;
            end
            GUARD: begin
                // After a framing error (break) the line must return high first.
                if (ctr_q >= extra) begin
                    if (!ferr_int_q || rxf_q) state_d = IDLE;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            taps_q       <= '0;
            rxf_q        <= 1'b0;
            rxf_prev_q   <= 1'b0;
            ctr_q        <= '0;
            bitcnt_q     <= '0;
            bd_q         <= CW'(2);
            nbits_q      <= 4'd5;
            stop_q       <= '0;
            ferr_int_q   <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= '0;
            perr_int_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            taps_q       <= taps_d;
            rxf_q        <= rxf_d;
            rxf_prev_q   <= rxf_prev_d;
            ctr_q        <= ctr_d;
            bitcnt_q     <= bitcnt_d;
            bd_q         <= bd_d;
            nbits_q      <= nbits_d;
            stop_q       <= stop_d;
            ferr_int_q   <= ferr_int_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            perr_int_q   <= perr_int_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Receive shift register is pure data and needs no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
